// File: rtl/debounce_bank.sv
// Multi-channel button debouncer: per-channel 2-FF synchroniser, stability counter,
// debounced level, press/release/hold strobes and an any-event flag.
module debounce_bank #(
    parameter int NCH         = 8,
    parameter int DB_CYCLES   = 1000000,
    parameter int HOLD_CYCLES = 50000000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic [NCH-1:0] button_in,
    output logic [NCH-1:0] button_out,
    output logic [NCH-1:0] press,
    // "release" is a reserved word in SystemVerilog, hence the suffix
    output logic [NCH-1:0] release_strb,
    output logic [NCH-1:0] hold,
    output logic           event_any
);

    localparam int            CW     = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic          s1_reg;
            logic          s2_reg;
            logic          level_reg;
            logic          press_reg;
            logic          release_reg;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (!n_reset) begin
                    s1_reg      <= 1'b0;
                    s2_reg      <= 1'b0;
                    cnt_reg     <= '0;
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    s1_reg <= button_in[gi] ^ ACTIVE_LOW;
                    s2_reg <= s1_reg;

                    // Counter saturates so a long-stable input never re-triggers
                    if (s1_reg != s2_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg != DB_MAX) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end

                    if ((cnt_reg == DB_MAX) && (s2_reg != level_reg)) begin
                        level_reg   <= s2_reg;
                        press_reg   <= s2_reg;
                        release_reg <= ~s2_reg;
                    end else begin
                        press_reg   <= 1'b0;
                        release_reg <= 1'b0;
                    end
                end
            end

            assign button_out[gi]   = level_reg;
            assign press[gi]        = press_reg;
            assign release_strb[gi] = release_reg;

            if (HOLD_CYCLES > 0) begin : g_hold
                localparam int            HW        = $clog2(HOLD_CYCLES + 1);
                localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
                localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

                logic [HW-1:0] hcnt_reg;
                logic          hold_reg;

                // The strobe fires on the edge where hcnt steps onto HOLD_MAX
                always_ff @(posedge clk) begin
                    if (!n_reset) begin
                        hcnt_reg <= '0;
                        hold_reg <= 1'b0;
                    end else begin
                        hold_reg <= 1'b0;
                        if (!level_reg || press_reg) begin
                            hcnt_reg <= '0;
                        end else if (hcnt_reg != HOLD_MAX) begin
                            hcnt_reg <= hcnt_reg + 1'b1;
                            hold_reg <= (hcnt_reg == HOLD_LAST);
                        end
                    end
                end

                assign hold[gi] = hold_reg;
            end else begin : g_no_hold
                assign hold[gi] = 1'b0;
            end
        end
    endgenerate

    assign event_any = |{press, release_strb, hold};

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: expected outputs are queued per clock edge as stimulus is
// driven, then popped and compared #1 after each rising edge.
module tb_debounce_bank;

    localparam int NCH  = 4;
    localparam int DB   = 4;
    localparam int HOLD = 20;

    logic           clk = 1'b0;
    logic           n_reset;
    logic [NCH-1:0] button_in;
    logic [NCH-1:0] button_out;
    logic [NCH-1:0] press;
    logic [NCH-1:0] release_strb;
    logic [NCH-1:0] hold;
    logic           event_any;

    debounce_bank #(
        .NCH        (NCH),
        .DB_CYCLES  (DB),
        .HOLD_CYCLES(HOLD),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .button_in   (button_in),
        .button_out  (button_out),
        .press       (press),
        .release_strb(release_strb),
        .hold        (hold),
        .event_any   (event_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        int       cyc;
        logic [3:0] bo;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] hd;
    } exp_t;

    typedef struct {
        string    name;
        logic [3:0] mask;
        int       low_cycles;
        bit       accept;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   edge_n = 0;
    int   total  = 0;
    int   bad    = 0;

    function automatic void push_exp(string name, int cyc, logic [3:0] bo, logic [3:0] pr,
                                     logic [3:0] rl, logic [3:0] hd);
        exp_t e;
        e.name = name;
        e.cyc  = cyc;
        e.bo   = bo;
        e.pr   = pr;
        e.rl   = rl;
        e.hd   = hd;
        sb_q.push_back(e);
    endfunction

    task automatic tick();
        exp_t        e;
        logic [16:0] act;
        logic [16:0] req;
        @(posedge clk);
        #1;
        edge_n++;
        while (sb_q.size() > 0 && sb_q[0].cyc <= edge_n) begin
            e   = sb_q.pop_front();
            req = {e.bo, e.pr, e.rl, e.hd, |{e.pr, e.rl, e.hd}};
            act = {button_out, press, release_strb, hold, event_any};
            total++;
            if (e.cyc != edge_n || act !== req) begin
                bad++;
                $display("FAIL %s edge %0d (due %0d): got bo=%b press=%b rel=%b hold=%b any=%b, need bo=%b press=%b rel=%b hold=%b any=%b",
                         e.name, edge_n, e.cyc, act[16:13], act[12:9], act[8:5], act[4:1], act[0],
                         req[16:13], req[12:9], req[8:5], req[4:1], req[0]);
            end
        end
    endtask

    task automatic tick_n(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pins in mask go low for n edges; accepted iff held long enough for the counter
    task automatic run_vector(vec_t v);
        int t = edge_n;
        int n = v.low_cycles;
        for (int k = 1; k <= n + 12; k++) begin
            push_exp(v.name, t + k,
                     (v.accept && k >= 7 && k <= n + 6) ? v.mask : 4'b0000,
                     (v.accept && k == 7) ? v.mask : 4'b0000,
                     (v.accept && k == n + 7) ? v.mask : 4'b0000,
                     4'b0000);
        end
        button_in = button_in & ~v.mask;
        tick_n(n);
        button_in = button_in | v.mask;
        tick_n(12);
        $display("vector %s: low %0d cycles, accept=%0d, edges %0d..%0d checked",
                 v.name, n, v.accept, t + 1, t + n + 12);
    endtask

    initial begin
        int t;

        vecs[0] = '{name: "ch1_bounce3",  mask: 4'b0010, low_cycles: 3,  accept: 1'b0};
        vecs[1] = '{name: "ch2_glitch1",  mask: 4'b0100, low_cycles: 1,  accept: 1'b0};
        vecs[2] = '{name: "ch3_short4",   mask: 4'b1000, low_cycles: 4,  accept: 1'b0};
        vecs[3] = '{name: "ch1_press6",   mask: 4'b0010, low_cycles: 6,  accept: 1'b1};
        vecs[4] = '{name: "ch0ch3_press8", mask: 4'b1001, low_cycles: 8, accept: 1'b1};
        vecs[5] = '{name: "all_press10",  mask: 4'b1111, low_cycles: 10, accept: 1'b1};

        // Reset state, then idle with all pins released (high)
        n_reset   = 1'b0;
        button_in = 4'b1111;
        for (int k = 1; k <= 13; k++) push_exp("reset_idle", k, 4'b0, 4'b0, 4'b0, 4'b0);
        tick_n(3);
        n_reset = 1'b1;
        tick_n(10);
        $display("reset_idle: edges 1..13 checked");

        for (int i = 0; i < 6; i++) run_vector(vecs[i]);

        // Ch0 press held: press at +7, hold once at +28, release strobe at +47
        t = edge_n;
        for (int k = 1; k <= 55; k++) begin
            push_exp("ch0_hold", t + k,
                     (k >= 7 && k <= 46) ? 4'b0001 : 4'b0000,
                     (k == 7)  ? 4'b0001 : 4'b0000,
                     (k == 47) ? 4'b0001 : 4'b0000,
                     (k == 28) ? 4'b0001 : 4'b0000);
        end
        button_in[0] = 1'b0;
        tick_n(40);
        button_in[0] = 1'b1;
        tick_n(15);
        $display("ch0_hold: press/hold/release sequence checked");

        // Release accepted 15 cycles after the press strobe cancels the hold
        t = edge_n;
        for (int k = 1; k <= 40; k++) begin
            push_exp("ch0_hold_cancel", t + k,
                     (k >= 7 && k <= 21) ? 4'b0001 : 4'b0000,
                     (k == 7)  ? 4'b0001 : 4'b0000,
                     (k == 22) ? 4'b0001 : 4'b0000,
                     4'b0000);
        end
        button_in[0] = 1'b0;
        tick_n(15);
        button_in[0] = 1'b1;
        tick_n(25);
        $display("ch0_hold_cancel: no hold after early release");

        // Ch2 and ch3 pressed and released together
        t = edge_n;
        for (int k = 1; k <= 25; k++) begin
            push_exp("ch23_together", t + k,
                     (k >= 7 && k <= 16) ? 4'b1100 : 4'b0000,
                     (k == 7)  ? 4'b1100 : 4'b0000,
                     (k == 17) ? 4'b1100 : 4'b0000,
                     4'b0000);
        end
        button_in[3:2] = 2'b00;
        tick_n(10);
        button_in[3:2] = 2'b11;
        tick_n(15);
        $display("ch23_together: simultaneous press and release checked");

        // Reset at cnt=3 on ch0; pin stays low so the press restarts from zero
        t = edge_n;
        for (int k = 1; k <= 30; k++) begin
            push_exp("ch0_reset_midcount", t + k,
                     (k >= 14 && k <= 22) ? 4'b0001 : 4'b0000,
                     (k == 14) ? 4'b0001 : 4'b0000,
                     (k == 23) ? 4'b0001 : 4'b0000,
                     4'b0000);
        end
        button_in[0] = 1'b0;
        tick_n(5);
        n_reset = 1'b0;
        tick_n(2);
        n_reset = 1'b1;
        tick_n(9);
        button_in[0] = 1'b1;
        tick_n(14);
        $display("ch0_reset_midcount: press 7 edges after reset release");

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, need 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
